// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment decode for the BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        SAT  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        BLANK_PRE  = 2'd0,
        ON         = 2'd1,
        BLANK_POST = 2'd2
    } phase_e;

    // Active-low segments, bit 0 = segment a.
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_BAD = 7'h3F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BAD;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load (clamped to 9), ripple carry/borrow in and out.
module bcd_digit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       inc,
    input  logic       dec,
    input  logic       step,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] d_q;
    logic [3:0] d_d;

    // Carry out does not depend on step, so the top can use the chain end as the
    // saturation detector without a combinational loop.
    assign cout  = cin & ((inc & (d_q == 4'd9)) | (dec & (d_q == 4'd0)));
    assign digit = d_q;

    always_comb begin
        d_d = d_q;
        if (load) begin
            d_d = (load_digit > 4'd9) ? 4'd9 : load_digit;
        end else if (step && cin) begin
            if (inc) begin
                d_d = (d_q == 4'd9) ? 4'd0 : d_q + 4'd1;
            end else if (dec) begin
                d_d = (d_q == 4'd0) ? 4'd9 : d_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= 4'd0;
        else          d_q <= d_d;
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD up/down stopwatch with prescaler, saturation and multiplexed 7-segment scan.
// Optional lap hold of the displayed frame with `define LAP_HOLD_EN.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int FREQ_W    = 5,
    parameter int BLANK_CYC = 1024,
    parameter int ON_CYC    = 14336
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef LAP_HOLD_EN
    input  logic                  lap,
`endif
    input  logic                  stop,
    input  logic                  start_up,
    input  logic                  start_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [FREQ_W-1:0]     frequency,
    output logic [4*DIGITS-1:0]   count,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  led_up,
    output logic                  led_down,
    output logic                  led_overflow,
    output mode_e                 mode_state,
    output phase_e                scan_phase
);

    localparam int PRE_W   = (1 << FREQ_W) - 1;
    localparam int CYC_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Prescaler: terminal value is 2**frequency-1, built as a right-shifted mask.
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_term;
    logic             tick;
    logic             cmd_any;

    assign pre_term = {PRE_W{1'b1}} >> (PRE_W - int'(frequency));
    assign tick     = (pre_q == pre_term);
    assign cmd_any  = stop | load | start_up | start_down;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               pre_q <= '0;
        else if (cmd_any || tick)   pre_q <= '0;
        else                        pre_q <= pre_q + PRE_W'(1);
    end

    // Mode FSM
    mode_e state_q, state_d;
    logic  ovf_q, ovf_d;
    logic  led_up_q, led_down_q;
    logic  do_load, do_step;
    logic  wrap;
    logic [DIGITS:0] carry;

    assign wrap = carry[DIGITS];

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        do_load = 1'b0;
        do_step = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (load) begin
            do_load = 1'b1;
            state_d = IDLE;
            ovf_d   = 1'b0;
        end else if (start_up) begin
            state_d = UP;
            ovf_d   = 1'b0;
        end else if (start_down) begin
            state_d = DOWN;
            ovf_d   = 1'b0;
        end else if (tick && (state_q == UP || state_q == DOWN)) begin
            if (wrap) begin
                state_d = SAT;
                ovf_d   = 1'b1;
            end else begin
                do_step = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ovf_q      <= 1'b0;
            led_up_q   <= 1'b0;
            led_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            led_up_q   <= (state_d == UP);
            led_down_q <= (state_d == DOWN);
        end
    end

    assign led_up       = led_up_q;
    assign led_down     = led_down_q;
    assign led_overflow = ovf_q;
    assign mode_state   = state_q;

    // Digit chain; carry[DIGITS] is set when every digit would wrap.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (do_load),
            .load_digit (load_value[4*g +: 4]),
            .inc        (state_q == UP),
            .dec        (state_q == DOWN),
            .step       (do_step),
            .cin        (carry[g]),
            .digit      (count[4*g +: 4]),
            .cout       (carry[g+1])
        );
    end

`ifdef LAP_HOLD_EN
    logic lap_q;
    logic hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_q <= 1'b0;
            hold  <= 1'b0;
        end else begin
            lap_q <= lap;
            if (lap && !lap_q) hold <= ~hold;
        end
    end
`else
    logic hold;
    assign hold = 1'b0;
`endif

    // Display scan FSM
    phase_e              phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] frame_q, frame_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        case (phase_q)
            BLANK_PRE: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    phase_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (cnt_q == CNT_W'(ON_CYC - 1)) begin
                    phase_d = BLANK_POST;
                    cnt_d   = '0;
                end
            end
            BLANK_POST: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    phase_d = BLANK_PRE;
                    cnt_d   = '0;
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        idx_d = '0;
                        if (!hold) frame_d = count;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                phase_d = BLANK_PRE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= BLANK_PRE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
        end
    end

    assign an         = (phase_q == ON) ? ~(DIGITS'(1) << idx_q) : '1;
    assign seg        = seg_decode(frame_q[4*idx_q +: 4]);
    assign dp         = 1'b1;
    assign scan_phase = phase_q;

endmodule
